// File: rtl/test_monitor.sv
// ---------------------------------------------------------------------------
// test_monitor
//   Watches the register-file write-back port of a core running a self-test
//   program and produces a sticky pass/fail verdict.
//
//   The program signals completion by writing 1 to DONE_REG. The pass flag
//   lives in RESULT_REG (1 = pass) and the current test number in TESTNUM_REG.
//   After the completion write the monitor waits DRAIN_CYCLES cycles so that
//   late write-backs still in flight can land, then freezes the verdict.
//
//   The snooped write-back is registered once before it is decoded. This
//   keeps the wide address/data compare off the core's write-back path. It
//   also fixes the completion latency: done rises DRAIN_CYCLES+1 edges after
//   the edge that samples the DONE_REG write. All "same cycle" references
//   below mean the registered copy of the write that the state machine sees
//   in the cycle concerned.
//
//   Optional feature: define TEST_MONITOR_WATCHDOG_EN to enable a RUN-state
//   watchdog. If no completion write arrives within TIMEOUT_CYCLES cycles,
//   the monitor enters TOUT with done=fail=timeout=1. Without the macro the
//   watchdog is absent and timeout is tied to 0.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active low
//   clr          in   synchronous re-arm for the next program, active high
//   wb_en        in   write-back register-file write enable
//   wb_addr      in   write-back destination register   [ADDR_W-1:0]
//   wb_data      in   write-back data                   [DATA_W-1:0]
//   done         out  verdict valid (sticky)
//   pass         out  test passed (valid with done)
//   fail         out  test failed or timed out (valid with done)
//   timeout      out  watchdog expired
//   fail_testnum out  test number frozen at the verdict  [DATA_W-1:0]
//   cycle_cnt    out  cycles spent in RUN + DRAIN, saturating [31:0]
// ---------------------------------------------------------------------------
module test_monitor #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int DONE_REG       = 26,
  parameter int RESULT_REG     = 27,
  parameter int TESTNUM_REG    = 3,
  parameter int DRAIN_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-1:0] fail_testnum,
  output logic [31:0]       cycle_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_TOUT  = 2'd3;

  localparam logic [ADDR_W-1:0] A_ZERO    = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] A_DONE    = ADDR_W'(DONE_REG);
  localparam logic [ADDR_W-1:0] A_RESULT  = ADDR_W'(RESULT_REG);
  localparam logic [ADDR_W-1:0] A_TESTNUM = ADDR_W'(TESTNUM_REG);
  localparam logic [DATA_W-1:0] D_ZERO    = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] D_ONE     = DATA_W'(1);
  localparam logic [7:0]        DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [31:0]       CNT_MAX    = 32'hFFFF_FFFF;

  // Reject illegal configurations at elaboration time.
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_bad_drain_cfg
    $error("test_monitor: DRAIN_CYCLES must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    $error("test_monitor: TIMEOUT_CYCLES must be >= 1");
  end

  logic              snp_en_r;
  logic [ADDR_W-1:0] snp_addr_r;
  logic [DATA_W-1:0] snp_data_r;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [7:0]        drain_cnt_r;
  logic [DATA_W-1:0] result_r;
  logic [DATA_W-1:0] testnum_r;
  logic [31:0]       cycle_cnt_r;
  logic              done_r;
  logic              pass_r;
  logic              fail_r;
  logic [DATA_W-1:0] fail_testnum_r;

  logic              snp_live_s;
  logic              hit_done_s;
  logic              hit_result_s;
  logic              hit_testnum_s;
  logic              done_write_s;
  logic [DATA_W-1:0] result_now_s;
  logic [DATA_W-1:0] testnum_now_s;
  logic              pass_now_s;
  logic              wd_expire_s;
  logic              active_s;

  // Register the snooped write-back; reset and re-arm discard it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snp_en_r   <= 1'b0;
      snp_addr_r <= A_ZERO;
      snp_data_r <= D_ZERO;
    end else if (clr) begin
      snp_en_r   <= 1'b0;
      snp_addr_r <= A_ZERO;
      snp_data_r <= D_ZERO;
    end else begin
      snp_en_r   <= wb_en;
      snp_addr_r <= wb_addr;
      snp_data_r <= wb_data;
    end
  end

  // Decode register hits. x0 is hard-wired, so writes to it never count.
  always_comb begin
    snp_live_s    = snp_en_r && (snp_addr_r != A_ZERO);
    hit_done_s    = snp_live_s && (snp_addr_r == A_DONE);
    hit_result_s  = snp_live_s && (snp_addr_r == A_RESULT);
    hit_testnum_s = snp_live_s && (snp_addr_r == A_TESTNUM);
    done_write_s  = hit_done_s && (snp_data_r == D_ONE);
    active_s      = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    // The verdict sees a write landing in the very cycle it is taken.
    if (hit_result_s) begin
      result_now_s = snp_data_r;
    end else begin
      result_now_s = result_r;
    end
    if (hit_testnum_s) begin
      testnum_now_s = snp_data_r;
    end else begin
      testnum_now_s = testnum_r;
    end
    pass_now_s = (result_now_s == D_ONE);
  end

`ifdef TEST_MONITOR_WATCHDOG_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  // Watchdog trips in the cycle the RUN counter reaches its last value.
  always_comb begin
    wd_expire_s = (cycle_cnt_r == TO_LAST);
  end
`else
  // No watchdog in this build.
  always_comb begin
    wd_expire_s = 1'b0;
  end
`endif

  // Next-state logic. A completion write outranks a same-cycle watchdog trip.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (done_write_s) begin
          state_nxt_s = ST_DRAIN;
        end else if (wd_expire_s) begin
          state_nxt_s = ST_TOUT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == 8'd0) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: state_nxt_s = ST_DONE;
      ST_TOUT: state_nxt_s = ST_TOUT;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // State, drain counter, cycle counter and shadow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= 8'd0;
      cycle_cnt_r <= 32'd0;
      result_r    <= D_ZERO;
      testnum_r   <= D_ZERO;
    end else if (clr) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= 8'd0;
      cycle_cnt_r <= 32'd0;
      result_r    <= D_ZERO;
      testnum_r   <= D_ZERO;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_RUN && done_write_s) begin
        drain_cnt_r <= DRAIN_LOAD;
      end else if (state_r == ST_DRAIN && drain_cnt_r != 8'd0) begin
        drain_cnt_r <= drain_cnt_r - 8'd1;
      end
      if (active_s && cycle_cnt_r != CNT_MAX) begin
        cycle_cnt_r <= cycle_cnt_r + 32'd1;
      end
      if (active_s && hit_result_s) begin
        result_r <= snp_data_r;
      end
      if (active_s && hit_testnum_s) begin
        testnum_r <= snp_data_r;
      end
    end
  end

`ifdef TEST_MONITOR_WATCHDOG_EN
  logic timeout_r;
`endif

  // Verdict registers: loaded only when DONE or TOUT is entered, sticky after.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
      fail_r         <= 1'b0;
      fail_testnum_r <= D_ZERO;
`ifdef TEST_MONITOR_WATCHDOG_EN
      timeout_r      <= 1'b0;
`endif
    end else if (state_r == ST_DRAIN && state_nxt_s == ST_DONE) begin
      done_r         <= 1'b1;
      pass_r         <= pass_now_s;
      fail_r         <= !pass_now_s;
      fail_testnum_r <= testnum_now_s;
    end else if (state_r == ST_RUN && state_nxt_s == ST_TOUT) begin
      done_r         <= 1'b1;
      pass_r         <= 1'b0;
      fail_r         <= 1'b1;
      fail_testnum_r <= testnum_now_s;
`ifdef TEST_MONITOR_WATCHDOG_EN
      timeout_r      <= 1'b1;
`endif
    end
  end

  assign done         = done_r;
  assign pass         = pass_r;
  assign fail         = fail_r;
  assign fail_testnum = fail_testnum_r;
  assign cycle_cnt    = cycle_cnt_r;
`ifdef TEST_MONITOR_WATCHDOG_EN
  assign timeout      = timeout_r;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_test_monitor.sv
// ---------------------------------------------------------------------------
// tb_test_monitor
//   Self-checking bench for test_monitor. Directed programs cover the
//   documented scenarios; randomized write-back traffic covers the rest.
//   A timeline model (edge numbers of re-arm, completion write and verdict)
//   predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_test_monitor;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int DR  = 10;
  localparam int TO  = 100;
  localparam int R_DONE = 26;
  localparam int R_RES  = 27;
  localparam int R_TN   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          done;
  logic          pass;
  logic          fail;
  logic          timeout;
  logic [DW-1:0] fail_testnum;
  logic [31:0]   cycle_cnt;

  int checks = 0;
  int errors = 0;

  // Model: all times are edge numbers.
  int          edge_n  = 0;
  int          m_start = 0;
  int          m_hit   = -1;
  bit          m_fin   = 1'b0;
  logic [31:0] m_res   = 32'd0;
  logic [31:0] m_tn    = 32'd0;
  logic        exp_done = 1'b0;
  logic        exp_pass = 1'b0;
  logic        exp_fail = 1'b0;
  logic        exp_to   = 1'b0;
  logic [31:0] exp_fnum = 32'd0;
  logic [31:0] exp_cnt  = 32'd0;

  test_monitor #(
    .DATA_W(DW), .ADDR_W(AW), .DONE_REG(R_DONE), .RESULT_REG(R_RES),
    .TESTNUM_REG(R_TN), .DRAIN_CYCLES(DR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .fail_testnum(fail_testnum), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  // Advance the model by one edge given the inputs sampled at that edge.
  function automatic void model_edge(input logic rst_v, input logic clr_v, input logic en,
                                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!rst_v || clr_v) begin
      m_start = edge_n; m_hit = -1; m_fin = 1'b0; m_res = 32'd0; m_tn = 32'd0;
      exp_done = 1'b0; exp_pass = 1'b0; exp_fail = 1'b0; exp_to = 1'b0;
      exp_fnum = 32'd0; exp_cnt = 32'd0;
    end else if (!m_fin) begin
      exp_cnt = 32'(edge_n - m_start);
      // Verdict uses writes sampled strictly before this edge.
      if (m_hit >= 0 && edge_n == m_hit + DR + 1) begin
        m_fin = 1'b1; exp_done = 1'b1; exp_pass = (m_res == 32'd1);
        exp_fail = !exp_pass; exp_fnum = m_tn;
      end
`ifdef TEST_MONITOR_WATCHDOG_EN
      else if (m_hit < 0 && edge_n == m_start + TO) begin
        m_fin = 1'b1; exp_done = 1'b1; exp_pass = 1'b0; exp_fail = 1'b1;
        exp_to = 1'b1; exp_fnum = m_tn;
      end
`endif
      if (!m_fin && en && a != 0) begin
        if (a == AW'(R_RES)) m_res = d;
        if (a == AW'(R_TN))  m_tn  = d;
        if (a == AW'(R_DONE) && d == 32'd1 && m_hit < 0) m_hit = edge_n;
      end
    end
  endfunction

  // One clock: drive inputs, take the edge, update model, compare outputs.
  task automatic cyc(input logic rst_v, input logic clr_v, input logic en,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    rst = rst_v; clr = clr_v; wb_en = en; wb_addr = a; wb_data = d;
    @(posedge clk);
    edge_n++;
    model_edge(rst_v, clr_v, en, a, d);
    #1;
    check("done", 32'(done), 32'(exp_done));
    check("pass", 32'(pass), 32'(exp_pass));
    check("fail", 32'(fail), 32'(exp_fail));
    check("timeout", 32'(timeout), 32'(exp_to));
    check("fail_testnum", fail_testnum, exp_fnum);
    check("cycle_cnt", cycle_cnt, exp_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    cyc(1'b1, 1'b0, 1'b1, AW'(a), d);
  endtask

  task automatic rearm();
    cyc(1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    #2;
    // Reset, including a write and clr that reset must override.
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 5'd26, 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_cnt", cycle_cnt, 32'd0);

    // Passing program: done exactly 11 edges after the completion write.
    wr(R_TN, 32'd5); wr(R_RES, 32'd1); wr(R_DONE, 32'd1);
    idle(10);
    check("pass_lat_early", 32'(done), 32'd0);
    idle(1);
    check("pass_lat_done", 32'(done), 32'd1);
    check("pass_flag", 32'(pass), 32'd1);
    check("pass_nofail", 32'(fail), 32'd0);
    check("pass_testnum", fail_testnum, 32'd5);
    wr(R_DONE, 32'd1); wr(R_TN, 32'd9); idle(3);
    check("pass_sticky_tn", fail_testnum, 32'd5);

    // Failing program, then re-arm clears everything.
    rearm();
    wr(R_TN, 32'd7); wr(R_RES, 32'd0); wr(R_DONE, 32'd1); idle(12);
    check("fail_flag", 32'(fail), 32'd1);
    check("fail_testnum", fail_testnum, 32'd7);
    cyc(1'b1, 1'b1, 1'b1, 5'd26, 32'd1);
    check("clr_done", 32'(done), 32'd0);
    check("clr_fail", 32'(fail), 32'd0);
    check("clr_tn", fail_testnum, 32'd0);
    check("clr_cnt", cycle_cnt, 32'd0);

    // Result written mid-drain still counts; DONE_REG=2 is ignored.
    rearm();
    wr(R_DONE, 32'd1); idle(3); wr(R_RES, 32'd1); idle(9);
    check("late_result_pass", 32'(pass), 32'd1);
    rearm();
    wr(R_DONE, 32'd2); idle(20);
    check("done2_ignored", 32'(done), 32'd0);

    // Watchdog behaviour.
    rearm();
    idle(TO + 5);
`ifdef TEST_MONITOR_WATCHDOG_EN
    check("wd_done", 32'(done), 32'd1);
    check("wd_timeout", 32'(timeout), 32'd1);
    check("wd_cnt", cycle_cnt, 32'(TO));
`else
    check("nowd_done", 32'(done), 32'd0);
    check("nowd_timeout", 32'(timeout), 32'd0);
`endif

    // Reset during drain, then a full fresh drain.
    rearm();
    wr(R_DONE, 32'd1); idle(4);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("rst_drain_done", 32'(done), 32'd0);
    idle(3); wr(R_DONE, 32'd1); idle(10);
    check("rst_redrain_early", 32'(done), 32'd0);
    idle(1);
    check("rst_redrain_done", 32'(done), 32'd1);

    // Randomized programs.
    for (int p = 0; p < 40; p++) begin
      rearm();
      for (int k = 0, n = $urandom_range(5, 60); k < n; k++) begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic en;
        en = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 4))
          0: a = 5'd3;
          1: a = 5'd26;
          2: a = 5'd27;
          3: a = 5'd0;
          default: a = AW'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0: d = 32'd0;
          1: d = 32'd1;
          2: d = 32'd2;
          default: d = $urandom;
        endcase
        if ($urandom_range(0, 59) == 0) cyc(1'b0, 1'b0, en, a, d);
        else if ($urandom_range(0, 29) == 0) cyc(1'b1, 1'b1, en, a, d);
        else cyc(1'b1, 1'b0, en, a, d);
      end
      idle(15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
